mp_job_issue: RTL and testbench

- Sits directly downstream of the job-manager MMIO control stage.
- Accepts process-info words over a start/ready handshake and buffers them in a small FIFO.
- Expands each entry into a sequence of descriptor-fetch requests (PASID, address, index, last) for the host-read engine.
- Provides back-pressure upstream, holding the upstream start level until a FIFO slot is free.

---
 rtl/mp_job_issue.sv | 136 +++++++++++++
 tb/tb_mp_job_issue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mp_job_issue.sv
// Job issue stage: buffers process-info words in a small FIFO and expands each
// job into a run of descriptor-fetch requests for the host-read engine.
module mp_job_issue #(
    parameter int PINFO_WIDTH = 88,
    parameter int PASID_WIDTH = 9,
    parameter int DEPTH       = 8,
    parameter int DESC_BYTES  = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PINFO_WIDTH-1:0]   process_info_i,
    input  logic                     process_start_i,
    output logic                     process_ready_o,
    output logic                     fetch_valid_o,
    input  logic                     fetch_ready_i,
    output logic [63:0]              fetch_addr_o,
    output logic [PASID_WIDTH-1:0]   fetch_pasid_o,
    output logic [7:0]               fetch_idx_o,
    output logic                     fetch_last_o,
    output logic                     job_done_o,
    output logic [$clog2(DEPTH):0]   queue_level_o,
    output logic                     busy_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 72 + PASID_WIDTH;
    localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    logic [EW-1:0]          r_mem [DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW:0]            r_count;
    state_t                 r_state;
    state_t                 w_state_next;
    logic [63:0]            r_addr;
    logic [PASID_WIDTH-1:0] r_pasid;
    logic [7:0]             r_cnt;
    logic [7:0]             r_idx;

    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_last;
    logic [EW-1:0]          w_head;
    logic [7:0]             w_head_cnt;

    // Only the addr/pasid/count fields are stored; anything above is dropped.
    generate
        if (PINFO_WIDTH > EW) begin : g_unused_bits
            logic w_unused;
            assign w_unused = ^process_info_i[PINFO_WIDTH-1:EW];
        end
    endgenerate

    assign w_full     = (r_count == FULL_LVL);
    assign w_push     = process_start_i & ~w_full;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_cnt = w_head[EW-1 -: 8];
    assign w_last     = (r_idx == r_cnt - 8'd1);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= process_info_i[EW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_pasid <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                {r_cnt, r_pasid, r_addr} <= w_head;
                r_idx                    <= '0;
            end else if (r_state == ISSUE && fetch_ready_i && !w_last) begin
                r_idx  <= r_idx + 8'd1;
                r_addr <= r_addr + 64'(DESC_BYTES);
            end
        end
    end

    // A zero-count job is retired straight out of IDLE without any request.
    always_comb begin
        w_state_next  = r_state;
        w_pop         = 1'b0;
        job_done_o    = 1'b0;
        fetch_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_pop = 1'b1;
                    if (w_head_cnt != 8'd0) w_state_next = ISSUE;
                    else                    job_done_o   = 1'b1;
                end
            end
            ISSUE: begin
                fetch_valid_o = 1'b1;
                if (fetch_ready_i && w_last) begin
                    job_done_o   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign process_ready_o = ~w_full;
    assign fetch_addr_o    = r_addr;
    assign fetch_pasid_o   = r_pasid;
    assign fetch_idx_o     = r_idx;
    assign fetch_last_o    = (r_state == ISSUE) && w_last;
    assign queue_level_o   = r_count;
    assign busy_o          = (r_count != '0) || (r_state != IDLE);

endmodule

// File: tb/tb_mp_job_issue.sv
// Scoreboard bench for mp_job_issue: stimulus pushes expected fetch requests,
// a negedge monitor pops and compares on every accepted request.
module tb_mp_job_issue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [87:0] process_info_i = '0;
    logic        process_start_i = 1'b0;
    logic        process_ready_o;
    logic        fetch_valid_o;
    logic        fetch_ready_i = 1'b1;
    logic [63:0] fetch_addr_o;
    logic [8:0]  fetch_pasid_o;
    logic [7:0]  fetch_idx_o;
    logic        fetch_last_o;
    logic        job_done_o;
    logic [3:0]  queue_level_o;
    logic        busy_o;

    mp_job_issue dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .process_info_i  (process_info_i),
        .process_start_i (process_start_i),
        .process_ready_o (process_ready_o),
        .fetch_valid_o   (fetch_valid_o),
        .fetch_ready_i   (fetch_ready_i),
        .fetch_addr_o    (fetch_addr_o),
        .fetch_pasid_o   (fetch_pasid_o),
        .fetch_idx_o     (fetch_idx_o),
        .fetch_last_o    (fetch_last_o),
        .job_done_o      (job_done_o),
        .queue_level_o   (queue_level_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] addr;
        logic [8:0]  pasid;
        logic [7:0]  idx;
        logic        last;
    } req_t;

    req_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_done   = 0;
    int          n_req    = 0;
    logic        stall_prev = 1'b0;
    logic [81:0] held;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [87:0] mk_info(input logic [63:0] addr, input logic [8:0] pasid,
                                            input logic [7:0] cnt);
        return {7'h55, cnt, pasid, addr};
    endfunction

    task automatic exp_req(input logic [63:0] addr, input logic [8:0] pasid,
                           input logic [7:0] idx, input logic last);
        req_t r;
        r.addr = addr; r.pasid = pasid; r.idx = idx; r.last = last;
        sb.push_back(r);
    endtask

    // Expected requests for a job: consecutive descriptors 128 bytes apart.
    task automatic exp_job(input logic [63:0] addr, input logic [8:0] pasid, input logic [7:0] cnt);
        for (int i = 0; i < int'(cnt); i++)
            exp_req(addr + 64'(i) * 64'd128, pasid, 8'(i), i == int'(cnt) - 1);
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic push(input logic [63:0] addr, input logic [8:0] pasid, input logic [7:0] cnt);
        logic was_ready;
        logic ok;
        ok = 1'b0;
        process_info_i  = mk_info(addr, pasid, cnt);
        process_start_i = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            was_ready = process_ready_o;
            @(posedge clk); #1;
            ok = was_ready;
        end
        process_start_i = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            if (!busy_o && sb.size() == 0) break;
        end
        chk("idle_busy", 128'(busy_o), 0);
        chk("sb_drained", 128'(sb.size()), 0);
        chk("idle_valid", 128'(fetch_valid_o), 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev)
                chk("stall_hold", {1'b1, fetch_valid_o, fetch_addr_o, fetch_pasid_o, fetch_idx_o, fetch_last_o},
                    {1'b1, 1'b1, held});
            if (job_done_o) n_done++;
            if (fetch_valid_o && fetch_ready_i) begin
                n_req++;
                if (sb.size() == 0) begin
                    chk("unexpected_req", {fetch_addr_o, fetch_pasid_o, fetch_idx_o, fetch_last_o}, 0);
                end else begin
                    chk("req", {fetch_addr_o, fetch_pasid_o, fetch_idx_o, fetch_last_o}, sb.pop_front());
                end
            end
            stall_prev <= fetch_valid_o && !fetch_ready_i;
            held       <= {fetch_addr_o, fetch_pasid_o, fetch_idx_o, fetch_last_o};
        end
    end

    initial begin
        int d0;
        int r0;
        logic [3:0] pat;

        // Reset values
        #23;
        chk("rst_ready", 128'(process_ready_o), 1);
        chk("rst_valid", 128'(fetch_valid_o), 0);
        chk("rst_level", 128'(queue_level_o), 0);
        chk("rst_busy",  128'(busy_o), 0);
        chk("rst_done",  128'(job_done_o), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single three-descriptor job
        d0 = n_done;
        exp_req(64'h1000, 9'h05, 8'd0, 1'b0);
        exp_req(64'h1080, 9'h05, 8'd1, 1'b0);
        exp_req(64'h1100, 9'h05, 8'd2, 1'b1);
        push(64'h1000, 9'h05, 8'd3);
        chk("t1_level_after_push", 128'(queue_level_o), 1);
        wait_idle();
        chk("t1_done_count", 128'(n_done - d0), 1);

        // Fill the FIFO behind a stalled job, then hold one more start
        d0 = n_done;
        fetch_ready_i = 1'b0;
        for (int j = 0; j < 9; j++) begin
            exp_job(64'h2000 + 64'(j) * 64'h100, 9'(j + 16), 8'd1);
            push(64'h2000 + 64'(j) * 64'h100, 9'(j + 16), 8'd1);
        end
        exp_job(64'h9000, 9'h1F, 8'd1);
        fork
            push(64'h9000, 9'h1F, 8'd1);
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("t2_ready_full", 128'(process_ready_o), 0);
                chk("t2_level_full", 128'(queue_level_o), 8);
                chk("t2_valid_stall", 128'(fetch_valid_o), 1);
                fetch_ready_i = 1'b1;
            end
        join
        wait_idle();
        chk("t2_done_count", 128'(n_done - d0), 10);

        // Stalls mid-job with ready pattern 1,0,0,1
        d0 = n_done;
        pat = 4'b1001;
        exp_job(64'h4000, 9'h0A, 8'd4);
        fork
            push(64'h4000, 9'h0A, 8'd4);
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                fetch_ready_i = pat[i % 4];
            end
        join
        fetch_ready_i = 1'b1;
        wait_idle();
        chk("t3_done_count", 128'(n_done - d0), 1);

        // Zero-count job sandwiched between single-descriptor jobs
        d0 = n_done;
        r0 = n_req;
        exp_req(64'h5000, 9'h11, 8'd0, 1'b1);
        exp_req(64'h7000, 9'h33, 8'd0, 1'b1);
        push(64'h5000, 9'h11, 8'd1);
        push(64'h6000, 9'h22, 8'd0);
        push(64'h7000, 9'h33, 8'd1);
        wait_idle();
        chk("t4_done_count", 128'(n_done - d0), 3);
        chk("t4_req_count", 128'(n_req - r0), 2);

        // 64-bit address wrap
        exp_req(64'hFFFF_FFFF_FFFF_FF80, 9'h1AB, 8'd0, 1'b0);
        exp_req(64'h0,                   9'h1AB, 8'd1, 1'b1);
        push(64'hFFFF_FFFF_FFFF_FF80, 9'h1AB, 8'd2);
        wait_idle();

        // Asynchronous reset while issuing with three entries queued
        fetch_ready_i = 1'b0;
        for (int j = 0; j < 4; j++) push(64'hA000 + 64'(j) * 64'h1000, 9'(j + 32), 8'd2);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_level_before", 128'(queue_level_o), 3);
        chk("t6_valid_before", 128'(fetch_valid_o), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_rst", 128'(fetch_valid_o), 0);
        chk("t6_level_rst", 128'(queue_level_o), 0);
        chk("t6_ready_rst", 128'(process_ready_o), 1);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        fetch_ready_i = 1'b1;
        d0 = n_done;
        exp_job(64'hC000, 9'h0C, 8'd2);
        push(64'hC000, 9'h0C, 8'd2);
        wait_idle();
        chk("t6_done_count", 128'(n_done - d0), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
